// File: rtl/branch_resolver.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolver
// Purpose  : Resolves BRANCH/JAL/JALR outcome against the front-end prediction
//            and sequences the redirect/flush handshake on a mispredict.
// Options  : define BRANCH_RESOLVER_STATS_EN to build the statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolver #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,

  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_kind,
  input  logic [2:0]   in_op,
  input  logic [N-1:0] in_pc,
  input  logic [N-1:0] in_imm,
  input  logic [N-1:0] in_rs1,
  input  logic [N-1:0] in_rs2,
  input  logic         in_pred_taken,
  input  logic [N-1:0] in_pred_target,

  output logic [2:0]   cmp_type,
  output logic [N-1:0] cmp_in1,
  output logic [N-1:0] cmp_in2,
  input  logic         cmp_out,

  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_taken,
  output logic [N-1:0] out_link,
  output logic [N-1:0] out_target,
  output logic         out_exc,

  output logic         redirect_valid,
  input  logic         redirect_ready,
  output logic [N-1:0] redirect_pc,
  output logic         flush,

  output logic [31:0]  stat_branches,
  output logic [31:0]  stat_mispredicts
);

  localparam logic [1:0] c_KIND_BRANCH = 2'b00;
  localparam logic [1:0] c_KIND_JAL    = 2'b01;
  localparam logic [1:0] c_KIND_JALR   = 2'b10;
  localparam logic [1:0] c_KIND_RSVD   = 2'b11;

  localparam logic [2:0] c_CMP_EQ      = 3'b000;
  localparam logic [2:0] c_OP_RSVD0    = 3'b010;
  localparam logic [2:0] c_OP_RSVD1    = 3'b011;

  localparam logic [1:0] c_ST_RUN      = 2'd0;
  localparam logic [1:0] c_ST_REDIRECT = 2'd1;
  localparam logic [1:0] c_ST_FLUSH    = 2'd2;

  localparam logic [N-1:0] c_FOUR      = N'(4);

  logic [1:0]   r_state;
  logic [1:0]   w_state_nxt;

  logic         w_accept;
  logic         w_taken;
  logic [N-1:0] w_pc_sum;
  logic [N-1:0] w_jalr_sum;
  logic [N-1:0] w_target;
  logic [N-1:0] w_link;
  logic         w_bad_op;
  logic         w_exc;
  logic         w_mispredict;

  // ---------------------------------------------------------------------------
  // Comparer request: only BRANCH needs a real compare.
  // ---------------------------------------------------------------------------
  always_comb begin
    cmp_type = c_CMP_EQ;
    cmp_in1  = '0;
    cmp_in2  = '0;
    if (in_kind == c_KIND_BRANCH) begin
      cmp_type = in_op;
      cmp_in1  = in_rs1;
      cmp_in2  = in_rs2;
    end
  end

  // ---------------------------------------------------------------------------
  // Outcome evaluation for the instruction presented this cycle.
  // ---------------------------------------------------------------------------
  assign w_pc_sum   = in_pc + in_imm;
  assign w_jalr_sum = in_rs1 + in_imm;
  assign w_link     = in_pc + c_FOUR;

  always_comb begin
    w_taken  = 1'b0;
    w_target = w_pc_sum;
    case (in_kind)
      c_KIND_BRANCH: w_taken = cmp_out;
      c_KIND_JAL:    w_taken = 1'b1;
      c_KIND_JALR: begin
        w_taken  = 1'b1;
        w_target = {w_jalr_sum[N-1:1], 1'b0};
      end
      c_KIND_RSVD:   w_taken = 1'b0;
      default:       w_taken = 1'b0;
    endcase
  end

  assign w_bad_op = (in_kind == c_KIND_BRANCH) &&
                    ((in_op == c_OP_RSVD0) || (in_op == c_OP_RSVD1));

  // Alignment only matters when control actually transfers.
  assign w_exc = (in_kind == c_KIND_RSVD) || w_bad_op ||
                 (w_taken && (w_target[1:0] != 2'b00));

  assign w_mispredict = !w_exc &&
                        ((w_taken != in_pred_taken) ||
                         (w_taken && (w_target != in_pred_target)));

  assign in_ready = (!out_valid || out_ready) && (r_state == c_ST_RUN);
  assign w_accept = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Result register; drains on out_ready regardless of the FSM state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_taken  <= 1'b0;
      out_exc    <= 1'b0;
      out_link   <= '0;
      out_target <= '0;
    end else if (w_accept) begin
      out_valid  <= 1'b1;
      out_taken  <= w_taken;
      out_exc    <= w_exc;
      out_link   <= w_link;
      out_target <= w_target;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // Redirect address is captured at the mispredicting accept and held.
  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_pc <= '0;
    end else if (w_accept && w_mispredict) begin
      redirect_pc <= w_taken ? w_target : w_link;
    end
  end

  // ---------------------------------------------------------------------------
  // Redirect FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_RUN: begin
        if (w_accept && w_mispredict) begin
          w_state_nxt = c_ST_REDIRECT;
        end
      end
      c_ST_REDIRECT: begin
        if (redirect_ready) begin
          w_state_nxt = c_ST_FLUSH;
        end
      end
      c_ST_FLUSH:    w_state_nxt = c_ST_RUN;
      default:       w_state_nxt = c_ST_RUN;
    endcase
  end

  always_comb begin
    redirect_valid = 1'b0;
    flush          = 1'b0;
    case (r_state)
      c_ST_REDIRECT: redirect_valid = 1'b1;
      c_ST_FLUSH:    flush          = 1'b1;
      default: begin
        redirect_valid = 1'b0;
        flush          = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else if (w_accept && !w_exc) begin
      if (r_stat_branches != 32'hFFFF_FFFF) begin
        r_stat_branches <= r_stat_branches + 32'd1;
      end
      if (w_mispredict && (r_stat_mispredicts != 32'hFFFF_FFFF)) begin
        r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
      end
    end
  end

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;
`else
  assign stat_branches    = 32'd0;
  assign stat_mispredicts = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolver.sv
`default_nettype none
// Directed bench for branch_resolver; an ideal comparer is modelled locally.
module tb_branch_resolver;
  localparam int N = 32;

`ifdef BRANCH_RESOLVER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic [1:0]   in_kind;
  logic [2:0]   in_op;
  logic [N-1:0] in_pc, in_imm, in_rs1, in_rs2, in_pred_target;
  logic         in_pred_taken;
  logic [2:0]   cmp_type;
  logic [N-1:0] cmp_in1, cmp_in2;
  logic         cmp_out;
  logic         out_valid, out_ready, out_taken, out_exc;
  logic [N-1:0] out_link, out_target;
  logic         redirect_valid, redirect_ready, flush;
  logic [N-1:0] redirect_pc;
  logic [31:0]  stat_branches, stat_mispredicts;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_br   = 0;
  int exp_mp   = 0;

  branch_resolver #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_op(in_op), .in_pc(in_pc), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .cmp_type(cmp_type), .cmp_in1(cmp_in1), .cmp_in2(cmp_in2), .cmp_out(cmp_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_link(out_link), .out_target(out_target), .out_exc(out_exc),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .flush(flush),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  // Reference comparer (branch funct3 encoding).
  always_comb begin
    case (cmp_type)
      3'b000:  cmp_out = (cmp_in1 == cmp_in2);
      3'b001:  cmp_out = (cmp_in1 != cmp_in2);
      3'b100:  cmp_out = ($signed(cmp_in1) <  $signed(cmp_in2));
      3'b101:  cmp_out = ($signed(cmp_in1) >= $signed(cmp_in2));
      3'b110:  cmp_out = (cmp_in1 <  cmp_in2);
      3'b111:  cmp_out = (cmp_in1 >= cmp_in2);
      default: cmp_out = 1'b0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] k, input logic [2:0] op,
                      input logic [31:0] pc, input logic [31:0] imm,
                      input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic pt, input logic [31:0] ptg);
    in_kind = k; in_op = op; in_pc = pc; in_imm = imm;
    in_rs1 = rs1; in_rs2 = rs2; in_pred_taken = pt; in_pred_target = ptg;
    in_valid = 1'b1;
  endtask

  function automatic logic [31:0] st(input int c);
    return STATS ? 32'(c) : 32'd0;
  endfunction

  // Called in the first REDIRECT cycle; releases the redirect immediately.
  task automatic do_redirect(input string tag, input logic [31:0] exp_pc);
    check({tag, "_rv"}, redirect_valid, 1);
    check({tag, "_rpc"}, redirect_pc, exp_pc);
    check({tag, "_inrdy"}, in_ready, 0);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    check({tag, "_flush"}, flush, 1);
    check({tag, "_rv_off"}, redirect_valid, 0);
    tick();
    check({tag, "_flush_off"}, flush, 0);
    check({tag, "_run"}, in_ready, 1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; redirect_ready = 1'b0;
    send(2'b00, 3'b000, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_rv", redirect_valid, 0);
    check("rst_flush", flush, 0);
    check("rst_link", out_link, 0);
    check("rst_target", out_target, 0);
    check("rst_rpc", redirect_pc, 0);
    check("rst_stat_br", stat_branches, 0);

    // Stray redirect_ready in RUN must be ignored.
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    check("stray_rr_rv", redirect_valid, 0);
    check("stray_rr_flush", flush, 0);
    check("stray_rr_inrdy", in_ready, 1);

    // BEQ correctly predicted taken.
    send(2'b00, 3'b000, 32'h100, 32'h20, 5, 5, 1, 32'h120);
    #1;
    check("beq_cmp_type", cmp_type, 3'b000);
    check("beq_cmp_in1", cmp_in1, 5);
    check("beq_cmp_in2", cmp_in2, 5);
    tick();
    in_valid = 1'b0; exp_br++;
    check("beq_valid", out_valid, 1);
    check("beq_taken", out_taken, 1);
    check("beq_target", out_target, 32'h120);
    check("beq_link", out_link, 32'h104);
    check("beq_exc", out_exc, 0);
    check("beq_rv", redirect_valid, 0);
    tick();
    check("beq_drained", out_valid, 0);

    // BLT mispredict: -1 < 1 signed, predicted not taken.
    send(2'b00, 3'b100, 32'h200, 32'h40, 32'hFFFF_FFFF, 1, 0, 0);
    #1;
    check("blt_cmp_type", cmp_type, 3'b100);
    tick();
    exp_br++; exp_mp++;
    send(2'b01, 3'b000, 32'h900, 0, 0, 0, 1, 32'h900);
    for (int c = 0; c < 3; c++) begin
      check("blt_rv", redirect_valid, 1);
      check("blt_rpc", redirect_pc, 32'h240);
      check("blt_inrdy", in_ready, 0);
      check("blt_flush", flush, 0);
      if (c == 0) begin
        check("blt_valid", out_valid, 1);
        check("blt_taken", out_taken, 1);
        check("blt_target", out_target, 32'h240);
      end else begin
        check("blt_drain", out_valid, 0);
      end
      if (c == 2) redirect_ready = 1'b1;
      tick();
    end
    redirect_ready = 1'b0;
    in_valid = 1'b0;
    check("blt_flush_on", flush, 1);
    check("blt_flush_rv", redirect_valid, 0);
    check("blt_flush_inrdy", in_ready, 0);
    tick();
    check("blt_flush_off", flush, 0);
    check("blt_run_inrdy", in_ready, 1);
    check("blt_no_stray_acc", out_valid, 0);

    // Misaligned JALR: excepting, never redirects.
    send(2'b10, 3'b000, 32'h300, 0, 32'h1003, 0, 0, 0);
    #1;
    check("jalr_cmp_type", cmp_type, 3'b000);
    check("jalr_cmp_in1", cmp_in1, 0);
    check("jalr_cmp_in2", cmp_in2, 0);
    tick();
    in_valid = 1'b0;
    check("jalr_exc", out_exc, 1);
    check("jalr_target", out_target, 32'h1002);
    check("jalr_taken", out_taken, 1);
    check("jalr_link", out_link, 32'h304);
    check("jalr_rv", redirect_valid, 0);
    check("jalr_inrdy", in_ready, 1);
    check("jalr_stat_mp", stat_mispredicts, st(exp_mp));
    check("jalr_stat_br", stat_branches, st(exp_br));

    // Reserved kind and reserved branch funct3.
    send(2'b11, 3'b000, 32'h310, 4, 0, 0, 0, 0);
    tick();
    check("rsvd_exc", out_exc, 1);
    check("rsvd_taken", out_taken, 0);
    send(2'b00, 3'b010, 32'h320, 8, 1, 1, 0, 0);
    tick();
    in_valid = 1'b0;
    check("op010_exc", out_exc, 1);
    check("op010_rv", redirect_valid, 0);
    tick();

    // Four back-to-back correctly predicted BNEs.
    for (int i = 0; i < 4; i++) begin
      send(2'b00, 3'b001, 32'h400 + 32'(16*i), 8, 32'(i), 32'(i+1), 1, 32'h408 + 32'(16*i));
      tick();
      exp_br++;
      check("b2b_valid", out_valid, 1);
      check("b2b_target", out_target, 32'h408 + 32'(16*i));
      check("b2b_inrdy", in_ready, 1);
    end
    in_valid = 1'b0;
    tick();

    // Back-pressure: payload held, in_ready low until drain.
    out_ready = 1'b0;
    send(2'b00, 3'b000, 32'h700, 32'h10, 7, 7, 1, 32'h710);
    tick();
    exp_br++;
    check("bp_valid", out_valid, 1);
    send(2'b00, 3'b101, 32'h800, 32'h20, 3, 2, 1, 32'h820);
    for (int c = 0; c < 3; c++) begin
      check("bp_inrdy", in_ready, 0);
      check("bp_hold_target", out_target, 32'h710);
      check("bp_hold_link", out_link, 32'h704);
      check("bp_hold_valid", out_valid, 1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_inrdy", in_ready, 1);
    tick();
    in_valid = 1'b0;
    exp_br++;
    check("bp_next_target", out_target, 32'h820);
    check("bp_next_link", out_link, 32'h804);
    check("bp_next_valid", out_valid, 1);
    tick();

    // JAL with wrong predicted target.
    send(2'b01, 3'b000, 32'h500, 32'h10, 0, 0, 1, 32'h600);
    tick();
    in_valid = 1'b0; exp_br++; exp_mp++;
    check("jal_target", out_target, 32'h510);
    check("jal_link", out_link, 32'h504);
    do_redirect("jal", 32'h510);

    // BGEU not taken but predicted taken: redirect to link.
    send(2'b00, 3'b111, 32'h600, 32'h20, 1, 2, 1, 32'h620);
    tick();
    in_valid = 1'b0; exp_br++; exp_mp++;
    check("bgeu_taken", out_taken, 0);
    do_redirect("bgeu", 32'h604);

    check("stat_branches", stat_branches, st(exp_br));
    check("stat_mispredicts", stat_mispredicts, st(exp_mp));

    // Reset in REDIRECT, alongside redirect_ready and in_valid.
    send(2'b00, 3'b001, 32'hA00, 32'h40, 1, 2, 0, 0);
    tick();
    in_valid = 1'b0;
    check("rstr_pre_rv", redirect_valid, 1);
    reset = 1'b1; redirect_ready = 1'b1;
    send(2'b01, 3'b000, 32'hB00, 32'h8, 0, 0, 0, 0);
    tick();
    reset = 1'b0; redirect_ready = 1'b0; in_valid = 1'b0;
    #1;
    check("rstr_rv", redirect_valid, 0);
    check("rstr_flush", flush, 0);
    check("rstr_valid", out_valid, 0);
    check("rstr_inrdy", in_ready, 1);
    check("rstr_rpc", redirect_pc, 0);
    check("rstr_target", out_target, 0);
    check("rstr_stat_br", stat_branches, 0);
    check("rstr_stat_mp", stat_mispredicts, 0);
    tick();
    check("rstr_no_flush", flush, 0);
    check("rstr_no_acc", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 The block SHALL have parameter N, default 32, the data/address width (XLEN).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have upstream handshake ports: in_valid in 1; in_ready out 1.
REQ-005 The block SHALL have upstream payload ports, all inputs: in_kind 2 (00 BRANCH, 01 JAL, 10 JALR, 11 reserved); in_op 3 (branch funct3, comparer_pkg encoding); in_pc N; in_imm N; in_rs1 N; in_rs2 N; in_pred_taken 1; in_pred_target N.
REQ-006 The block SHALL have comparer-side ports: cmp_type out 3; cmp_in1 out N; cmp_in2 out N; cmp_out in 1, the combinational result of an external comparer.
REQ-007 The block SHALL have downstream ports: out_valid out 1; out_ready in 1; out_taken out 1; out_link out N (pc+4); out_target out N; out_exc out 1.
REQ-008 The block SHALL have redirect ports: redirect_valid out 1; redirect_ready in 1; redirect_pc out N; flush out 1.
REQ-009 The block SHALL have statistics ports: stat_branches out 32; stat_mispredicts out 32.

Function
REQ-010 The block SHALL accept an instruction on a cycle where in_valid && in_ready (an "accept").
REQ-011 For BRANCH it SHALL drive cmp_type=in_op, cmp_in1=in_rs1, cmp_in2=in_rs2; for other kinds it SHALL drive CMP_EQ, 0, 0.
REQ-012 Actual taken SHALL be: BRANCH -> cmp_out; JAL, JALR -> 1; reserved -> 0.
REQ-013 Target SHALL be: BRANCH, JAL -> in_pc+in_imm; JALR -> (in_rs1+in_imm) with bit 0 cleared; all sums mod 2^N.
REQ-014 out_link SHALL equal in_pc+4 mod 2^N.
REQ-015 out_exc SHALL be set for: reserved in_kind; BRANCH with in_op 010 or 011; taken with target[1:0]!=0.
REQ-016 Results SHALL be registered: out_valid rises the cycle after accept (latency 1).
REQ-017 out_* SHALL be held stable while out_valid && !out_ready.
REQ-018 The block SHALL assert in_ready = (!out_valid || out_ready) && state==RUN, giving one accept per cycle.
REQ-019 An accept SHALL be a mispredict when !out_exc && (taken!=in_pred_taken || (taken && target!=in_pred_target)).
REQ-020 The FSM SHALL have states RUN, REDIRECT, FLUSH, with transitions: RUN -> REDIRECT on mispredict accept; REDIRECT -> FLUSH when redirect_ready; FLUSH -> RUN after exactly one cycle.
REQ-021 In REDIRECT the block SHALL hold redirect_valid=1 and redirect_pc stable, equal to target if taken, else link.
REQ-022 In FLUSH the block SHALL hold flush=1 for that single cycle.
REQ-023 redirect_valid and flush SHALL be 0 in all other states.
REQ-024 redirect_ready asserted outside REDIRECT SHALL be ignored.
REQ-025 The output register SHALL drain independently of the FSM, so out_ready may complete in REDIRECT and FLUSH.
REQ-026 An excepting instruction SHALL never redirect, be counted as a mispredict, or change state.

Reset
REQ-027 When reset is high at a clock edge, state SHALL become RUN, and out_valid, out_taken, out_exc, redirect_valid, flush SHALL become 0, and out_link, out_target, redirect_pc SHALL become 0.
REQ-028 Reset SHALL override a simultaneous accept or redirect handshake, including reset mid-REDIRECT.
REQ-029 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-030 Macro BRANCH_RESOLVER_STATS_EN SHALL select whether statistics counters are present.
REQ-031 With BRANCH_RESOLVER_STATS_EN defined: stat_branches SHALL increment on every non-excepting accept; stat_mispredicts SHALL increment on every mispredict accept; both SHALL saturate at 2^32-1 and reset to 0.
REQ-032 Without BRANCH_RESOLVER_STATS_EN: both stat ports SHALL be tied to constant 0 and no counter flops SHALL be synthesised.

Verification
REQ-033 BEQ, pc=0x100, imm=0x20, rs1=rs2=5, pred_taken=1, pred_target=0x120 -> next cycle out_valid=1, taken=1, target=0x120, link=0x104, no redirect.
REQ-034 BLT, rs1=0xFFFFFFFF, rs2=1, pred_taken=0, pc=0x200, imm=0x40 -> taken=1; REDIRECT with redirect_pc=0x240 held 3 cycles until redirect_ready; then flush=1 for 1 cycle; in_ready=0 throughout.
REQ-035 JALR, rs1=0x1003, imm=0 -> target=0x1002, out_exc=1, no redirect, stat_mispredicts unchanged.
REQ-036 Back-to-back 4 correctly predicted branches with out_ready=1 -> 4 consecutive out_valid cycles; with out_ready=0 -> in_ready drops after the first and payload stays stable.
REQ-037 Reset asserted in REDIRECT -> next cycle redirect_valid=0, flush=0, out_valid=0, in_ready=1.
REQ-038 With BRANCH_RESOLVER_STATS_EN defined, 10 accepts including 3 mispredicts -> stat_branches=10, stat_mispredicts=3; without the macro -> both 0.
